// File: rtl/furv_mem.sv
// Memory-access stage of the furv pipeline: captures a load/store from execute,
// runs one single-outstanding bus request and hands the raw result to writeback.
module furv_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        mem_i,
  input  logic        we_i,
  input  logic [1:0]  mem_width_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        valid_o,
  output logic        mem_o,
  output logic        mem_ack_o,
  output logic [31:0] data_o,
  output logic [1:0]  byte_addr_o,
  output logic        misaligned_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  logic [0:0]  state_reg;
  logic        misaligned;
  logic        mem_op;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;

  assign mem_op = valid_i && mem_i;

  // Lane placement of store data and byte enables; loads share the sel pattern.
  always_comb begin
    misaligned = 1'b0;
    sel_next   = 4'b1111;
    wdata_next = store_data_i;
    case (mem_width_i)
      2'd0: begin
        sel_next   = 4'b0001 << addr_i[1:0];
        wdata_next = {4{store_data_i[7:0]}};
      end
      2'd1: begin
        misaligned = addr_i[0];
        sel_next   = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{store_data_i[15:0]}};
      end
      default: misaligned = |addr_i[1:0];
    endcase
    if (!we_i) wdata_next = 32'd0;
  end

  assign stall_o   = stall_i || (state_reg == ST_BUS);
  assign bus_stb_o = bus_cyc_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      valid_o      <= 1'b0;
      mem_o        <= 1'b0;
      mem_ack_o    <= 1'b0;
      misaligned_o <= 1'b0;
      bus_cyc_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= 32'd0;
      bus_wdata_o  <= 32'd0;
      bus_sel_o    <= 4'd0;
      data_o       <= 32'd0;
      byte_addr_o  <= 2'd0;
    end else if (state_reg == ST_BUS) begin
      // Request stays frozen on the bus until the slave acknowledges it.
      if (bus_ack_i) begin
        state_reg <= ST_IDLE;
        bus_cyc_o <= 1'b0;
        bus_we_o  <= 1'b0;
        data_o    <= bus_we_o ? 32'd0 : bus_rdata_i;
        mem_ack_o <= 1'b1;
      end
    end else if (!stall_i) begin
      valid_o      <= valid_i;
      mem_o        <= mem_op;
      byte_addr_o  <= addr_i[1:0];
      data_o       <= 32'd0;
      misaligned_o <= mem_op && misaligned;
      if (mem_op && !misaligned) begin
        state_reg   <= ST_BUS;
        bus_cyc_o   <= 1'b1;
        bus_we_o    <= we_i;
        bus_addr_o  <= {addr_i[31:2], 2'b00};
        bus_wdata_o <= wdata_next;
        bus_sel_o   <= sel_next;
        mem_ack_o   <= 1'b0;
      end else begin
        // Misaligned ops complete immediately so writeback never waits on them.
        mem_ack_o <= mem_op && misaligned;
      end
    end
  end

endmodule

// File: tb/tb_furv_mem.sv
// Self-checking bench for furv_mem: per-scenario tasks with a result scoreboard.
module tb_furv_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, mem_i = 1'b0, we_i = 1'b0;
  logic [1:0]  mem_width_i = 2'd0;
  logic [31:0] addr_i = 32'd0, store_data_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        stall_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;
  logic        valid_o, mem_o, mem_ack_o, misaligned_o;
  logic [31:0] data_o;
  logic [1:0]  byte_addr_o;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  furv_mem dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_i(mem_i), .we_i(we_i),
    .mem_width_i(mem_width_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .stall_i(stall_i), .stall_o(stall_o), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .valid_o(valid_o), .mem_o(mem_o), .mem_ack_o(mem_ack_o), .data_o(data_o),
    .byte_addr_o(byte_addr_o), .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  // Present one instruction for exactly one capture edge.
  task automatic issue(input logic mem, input logic we, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    valid_i = 1'b1; mem_i = mem; we_i = we; mem_width_i = w; addr_i = a; store_data_i = d;
    @(posedge clk); #1;
    valid_i = 1'b0; mem_i = 1'b0; we_i = 1'b0;
  endtask

  // Bus slave: acks after `waits` wait states, counts cycles with cyc high and
  // records the request seen in the first bus cycle. Bounded to 20 cycles.
  task automatic bus_slave(input int waits, input logic [31:0] rdata, output int ncyc,
                           output logic [31:0] a, output logic [31:0] wd,
                           output logic [3:0] sel, output logic we, output logic stb_ok);
    ncyc = 0; a = 'x; wd = 'x; sel = 'x; we = 1'bx; stb_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_cyc_o) begin
        if (bus_stb_o !== 1'b1) stb_ok = 1'b0;
        if (ncyc == 0) begin a = bus_addr_o; wd = bus_wdata_o; sel = bus_sel_o; we = bus_we_o; end
        ncyc++;
        if (ncyc == waits + 1) begin bus_ack_i = 1'b1; bus_rdata_i = rdata; end
      end else if (ncyc > 0) begin
        break;
      end
      @(posedge clk); #1;
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({valid_o, mem_o, mem_ack_o, misaligned_o, bus_cyc_o, bus_stb_o, bus_we_o, stall_o} !== 8'd0 ||
        bus_addr_o !== 0 || bus_wdata_o !== 0 || bus_sel_o !== 0 || data_o !== 0 || byte_addr_o !== 0) begin
      bad++;
      $display("FAIL reset_state: cyc=%b valid=%b ack=%b data=%h sel=%b (required all zero)",
               bus_cyc_o, valid_o, mem_ack_o, data_o, bus_sel_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_word_load();
    int n; logic [31:0] a, wd; logic [3:0] sel; logic we, stb_ok; logic [31:0] e;
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0);
    bus_slave(2, 32'hDEADBEEF, n, a, wd, sel, we, stb_ok);
    total++; if (n !== 3) begin bad++; $display("FAIL wload_cyc_cycles: got %0d want 3", n); end
    total++; if (a !== 32'h1000 || sel !== 4'b1111 || we !== 1'b0 || !stb_ok) begin
      bad++; $display("FAIL wload_req: addr=%h sel=%b we=%b stb_ok=%b want 1000/1111/0/1", a, sel, we, stb_ok); end
    e = exp_q.pop_front();
    total++; if (data_o !== e || mem_ack_o !== 1'b1 || stall_o !== 1'b0) begin
      bad++; $display("FAIL wload_result: data=%h ack=%b stall=%b want %h/1/0", data_o, mem_ack_o, stall_o, e); end
    $display("word load 0x1000: data=%h cycles=%0d", data_o, n);
  endtask

  task automatic test_stores();
    int n; logic [31:0] a, wd; logic [3:0] sel; logic we, stb_ok;
    issue(1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'h0000_00A5);
    bus_slave(0, 32'hFFFF_FFFF, n, a, wd, sel, we, stb_ok);
    total++; if (wd !== 32'hA5A5A5A5 || sel !== 4'b1000 || we !== 1'b1 || a !== 32'h1000 || n !== 1) begin
      bad++; $display("FAIL byte_store: wdata=%h sel=%b we=%b addr=%h n=%0d want a5a5a5a5/1000/1/1000/1",
                      wd, sel, we, a, n); end
    total++; if (data_o !== 32'h0 || mem_ack_o !== 1'b1 || byte_addr_o !== 2'd3) begin
      bad++; $display("FAIL byte_store_result: data=%h ack=%b boff=%0d want 0/1/3", data_o, mem_ack_o, byte_addr_o); end
    $display("byte store 0x1003: wdata=%h sel=%b", wd, sel);
    issue(1'b1, 1'b1, 2'd1, 32'h0000_1002, 32'hFFFF_1234);
    bus_slave(1, 32'h0, n, a, wd, sel, we, stb_ok);
    total++; if (wd !== 32'h12341234 || sel !== 4'b1100 || we !== 1'b1 || n !== 2) begin
      bad++; $display("FAIL half_store: wdata=%h sel=%b we=%b n=%0d want 12341234/1100/1/2", wd, sel, we, n); end
    $display("half store 0x1002: wdata=%h sel=%b", wd, sel);
    issue(1'b1, 1'b0, 2'd0, 32'h0000_2002, 32'h0);
    bus_slave(0, 32'h11223344, n, a, wd, sel, we, stb_ok);
    total++; if (sel !== 4'b0100 || wd !== 32'h0 || data_o !== 32'h11223344) begin
      bad++; $display("FAIL byte_load: sel=%b wdata=%h data=%h want 0100/0/11223344", sel, wd, data_o); end
    $display("byte load 0x2002: sel=%b data=%h", sel, data_o);
  endtask

  task automatic test_misaligned();
    int seen;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_1001, 32'h0);
    seen = 0;
    @(negedge clk);
    if (bus_cyc_o) seen++;
    total++; if (misaligned_o !== 1'b1 || mem_ack_o !== 1'b1 || valid_o !== 1'b1 || stall_o !== 1'b0) begin
      bad++; $display("FAIL misaligned_word: mis=%b ack=%b valid=%b stall=%b want 1/1/1/0",
                      misaligned_o, mem_ack_o, valid_o, stall_o); end
    issue(1'b1, 1'b1, 2'd1, 32'h0000_1003, 32'h5555);
    @(negedge clk);
    if (bus_cyc_o) seen++;
    total++; if (seen != 0 || misaligned_o !== 1'b1 || mem_ack_o !== 1'b1) begin
      bad++; $display("FAIL misaligned_half: cyc_seen=%0d mis=%b ack=%b want 0/1/1", seen, misaligned_o, mem_ack_o); end
    $display("misaligned word 0x1001 / half 0x1003: mis=%b", misaligned_o);
    issue(1'b0, 1'b0, 2'd2, 32'h0000_1001, 32'h0);
    @(negedge clk);
    total++; if (valid_o !== 1'b1 || mem_o !== 1'b0 || mem_ack_o !== 1'b0 || misaligned_o !== 1'b0 || bus_cyc_o !== 1'b0) begin
      bad++; $display("FAIL non_mem: valid=%b mem=%b ack=%b mis=%b cyc=%b want 1/0/0/0/0",
                      valid_o, mem_o, mem_ack_o, misaligned_o, bus_cyc_o); end
    $display("non-memory op: valid=%b mem=%b", valid_o, mem_o);
  endtask

  task automatic test_stall();
    int n; logic [31:0] a, wd; logic [3:0] sel; logic we, stb_ok; logic [31:0] e;
    int badhold;
    exp_q.push_back(32'hCAFE_F00D);
    issue(1'b1, 1'b0, 2'd2, 32'h0000_3000, 32'h0);
    stall_i = 1'b1;
    bus_slave(0, 32'hCAFE_F00D, n, a, wd, sel, we, stb_ok);
    total++; if (n !== 1) begin bad++; $display("FAIL stall_cyc_cycles: got %0d want 1", n); end
    e = exp_q.pop_front();
    badhold = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (data_o !== e || mem_ack_o !== 1'b1 || stall_o !== 1'b1 || bus_cyc_o !== 1'b0) badhold++;
    end
    total++; if (badhold != 0) begin
      bad++; $display("FAIL stall_hold: %0d bad cycles, data=%h ack=%b stall=%b want %h/1/1", badhold, data_o, mem_ack_o, stall_o, e); end
    stall_i = 1'b0;
    @(negedge clk);
    $display("stalled load 0x3000: data=%h held 3 cycles", e);
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] a, wd; logic [3:0] sel; logic we, stb_ok; logic [31:0] e;
    exp_q.push_back(32'h1111_0001);
    exp_q.push_back(32'h2222_0002);
    issue(1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0);
    bus_slave(0, 32'h1111_0001, n, a, wd, sel, we, stb_ok);
    e = exp_q.pop_front();
    total++; if (data_o !== e || bus_cyc_o !== 1'b0 || n !== 1) begin
      bad++; $display("FAIL b2b_first: data=%h cyc=%b n=%0d want %h/0/1", data_o, bus_cyc_o, n, e); end
    issue(1'b1, 1'b0, 2'd2, 32'h0000_4004, 32'h0);
    bus_slave(0, 32'h2222_0002, n, a, wd, sel, we, stb_ok);
    e = exp_q.pop_front();
    total++; if (data_o !== e || a !== 32'h4004 || n !== 1) begin
      bad++; $display("FAIL b2b_second: data=%h addr=%h n=%0d want %h/4004/1", data_o, a, n, e); end
    $display("back-to-back loads: second data=%h", data_o);
  endtask

  task automatic test_reset_mid_bus();
    int seen;
    issue(1'b1, 1'b0, 2'd2, 32'h0000_5000, 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus_cyc_o !== 1'b0 || bus_stb_o !== 1'b0 || valid_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL async_reset: cyc=%b stb=%b valid=%b stall=%b want 0/0/0/0",
                      bus_cyc_o, bus_stb_o, valid_o, stall_o); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus_cyc_o || stall_o) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL reset_no_reissue: active cycles=%0d want 0", seen); end
    $display("reset mid-bus: request abandoned");
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_stores();
    test_misaligned();
    test_stall();
    test_back_to_back();
    test_reset_mid_bus();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
